hash_wbuf_drain: RTL and testbench
==================================

Name: hash_wbuf_drain

Overview:
- Responder on the multiplier's HASH-side BRAM port (addr_HASH / wen_HASH / write data / read data / HASH_ready).
- Captures the 64-bit result words the multiplier writes, serves 1-cycle-latency reads, and on a flush drains the captured block in index order to the hash absorber over a valid/ready stream.
- Holds HASH_ready low while a drain is in progress, so the multiplier cannot write again until the buffer is empty.

Parameters:
- DATA_WIDTH, 64, word width on the BRAM and stream sides.
- DEPTH, 32, buffer depth in words; power of two, at least 2.
- ADDR_WIDTH, 32, width of the byte address from the multiplier.
- ADDR_LSB, 3, byte-to-word shift (log2 of DATA_WIDTH/8).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- addr_HASH  input  ADDR_WIDTH  byte address from the multiplier
- wen_HASH  input  1  write enable
- wdata_HASH  input  DATA_WIDTH  write data
- rdata_HASH  output  DATA_WIDTH  read data, 1-cycle latency
- flush  input  1  single-cycle pulse: the written block is complete, start the drain
- HASH_ready  output  1  high when the buffer accepts writes
- m_valid  output  1  stream word valid
- m_data  output  DATA_WIDTH  stream word
- m_last  output  1  marks the final word of the drain
- m_ready  input  1  absorber accepts the stream word
- drain_done  output  1  single-cycle pulse when a drain completes
- wr_err  output  1  sticky error flag, cleared only by rst

Behaviour:
- One clock; rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values:
  - state = FILL, count = 0, rd_ptr = 0.
  - HASH_ready = 1, m_valid = 0, m_last = 0, m_data = 0, rdata_HASH = 0, drain_done = 0, wr_err = 0.
  - Memory contents are not cleared.
- Word index: idx = addr_HASH[ADDR_LSB +: log2(DEPTH)].
  - The address is out of range when any bit above that field is nonzero.
- Read port:
  - Every cycle, rdata_HASH <= mem[idx], in any state.
  - On read-during-write to the same idx, rdata_HASH returns the old data.
- Write rules in FILL (wen_HASH=1, address in range):
  - mem[idx] <= wdata_HASH.
  - count <= max(count, idx+1), a high-water mark.
  - Gaps below the high-water mark are drained with whatever the memory holds.
- Rejected writes (memory and count unchanged, wr_err <= 1):
  - out-of-range address;
  - wen_HASH=1 in DRAIN.
- State FILL:
  - HASH_ready = 1.
  - On flush with an effective count (including a same-cycle write) of 0: stay in FILL and pulse drain_done for one cycle.
  - On flush with an effective count above 0: go to DRAIN, rd_ptr <= 0.
  - On flush and wen_HASH in the same cycle: the write commits first and is counted in the drain.
- State DRAIN:
  - HASH_ready = 0.
  - Stream rules:
    - Words are presented in order, mem[0] .. mem[count-1].
    - m_data is registered; the first m_valid appears 1 cycle after entering DRAIN.
    - Once m_valid is high, m_data and m_last stay stable until m_valid && m_ready.
    - With m_ready held high, throughput is 1 word per cycle, with no bubble between words.
    - m_last = 1 exactly on the word with index count-1.
  - Last-word handshake, same edge:
    - m_valid <= 0, state <= FILL, count <= 0.
    - drain_done pulses for 1 cycle.
    - HASH_ready returns to 1 in the following cycle.
  - flush in DRAIN is ignored and does not set wr_err.
- Counter widths:
  - count is log2(DEPTH)+1 bits, range 0..DEPTH.
  - rd_ptr is log2(DEPTH) bits; it never wraps because the drain stops at count-1.
- Full buffer: count = DEPTH is legal and drains all DEPTH words.
- Reset mid-drain: the stream aborts immediately, with m_valid = 0 on the next cycle and state = FILL. No partial m_last is ever emitted after rst.

Test Plan:
- Write words at byte addresses 0x00, 0x08, 0x10 with data A0, A1, A2, then flush; hold m_ready = 1 -> the stream is A0, A1, A2 on consecutive cycles, m_last only on A2. drain_done pulses on A2's handshake edge, and HASH_ready = 0 from the flush edge until the cycle after.
- Backpressure: drain 4 words with m_ready toggling 1,0,0,1,0,1,1 -> exactly 4 handshakes in order, with m_data and m_last stable during every stall.
- Write at address 0x08 only (value B), then flush -> 2 words are drained, mem[0] then B. Then write to byte address DEPTH*8 = 0x100 -> wr_err = 1, count unchanged.
- flush in the same cycle as a write to addr 0x18 with data C, after writes to indices 0..2 -> the drain is 4 words, the last is C with m_last = 1.
- Assert wen_HASH during DRAIN -> write dropped, memory readback unchanged via rdata_HASH one cycle later, wr_err = 1. Assert rst mid-drain -> next cycle m_valid = 0, HASH_ready = 1, wr_err = 0.
- flush with an empty buffer -> drain_done pulses one cycle, m_valid never rises, HASH_ready stays 1.

Source files
------------

// File: rtl/hash_wbuf_drain_if.sv
// Bundle of the multiplier-side BRAM port, the flush/status sideband and the
// absorber-side valid/ready stream for hash_wbuf_drain.
interface hash_wbuf_drain_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr_HASH;
  logic                  wen_HASH;
  logic [DATA_WIDTH-1:0] wdata_HASH;
  logic [DATA_WIDTH-1:0] rdata_HASH;
  logic                  HASH_ready;
  logic                  flush;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  m_ready;
  logic                  drain_done;
  logic                  wr_err;

  modport master (
    output addr_HASH, wen_HASH, wdata_HASH, flush, m_ready,
    input  rdata_HASH, HASH_ready, m_valid, m_data, m_last, drain_done, wr_err
  );

  modport slave (
    input  addr_HASH, wen_HASH, wdata_HASH, flush, m_ready,
    output rdata_HASH, HASH_ready, m_valid, m_data, m_last, drain_done, wr_err
  );
endinterface

// File: rtl/hash_wbuf_drain.sv
// Write buffer between the multiplier's HASH BRAM port and the hash absorber:
// captures a block of result words, then streams it out in index order on flush.
module hash_wbuf_drain #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ADDR_LSB   = 3
) (
  input logic             clk,
  input logic             rst,
  hash_wbuf_drain_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic {FILL, DRAIN} state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0]      count_q;
  logic [IDX_W-1:0]      rd_ptr_q;
  logic                  m_valid_q, m_last_q, drain_done_q, wr_err_q;
  logic [DATA_WIDTH-1:0] m_data_q, rdata_q;

  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic [CNT_W-1:0] idx_p1, count_eff;
  logic             ptr_at_last;
  logic             wr_commit, wr_reject, drain_start, flush_empty, load_word, drain_finish;

  assign idx         = IDX_W'(bus.addr_HASH >> ADDR_LSB);
  assign in_range    = (bus.addr_HASH >> (ADDR_LSB + IDX_W)) == '0;
  assign idx_p1      = {1'b0, idx} + CNT_W'(1);
  assign ptr_at_last = ({1'b0, rd_ptr_q} + CNT_W'(1)) == count_q;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    wr_commit    = 1'b0;
    wr_reject    = 1'b0;
    count_eff    = count_q;
    drain_start  = 1'b0;
    flush_empty  = 1'b0;
    load_word    = 1'b0;
    drain_finish = 1'b0;

    case (state_q)
      FILL: begin
        if (bus.wen_HASH) begin
          wr_commit = in_range;
          wr_reject = !in_range;
        end
        // High-water mark, so a same-cycle write is counted in the drain it triggers
        if (wr_commit && (idx_p1 > count_q)) count_eff = idx_p1;
        if (bus.flush) begin
          if (count_eff == '0) begin
            flush_empty = 1'b1;
          end else begin
            drain_start = 1'b1;
            state_d     = DRAIN;
          end
        end
      end
      DRAIN: begin
        wr_reject = bus.wen_HASH;
        if (m_valid_q && bus.m_ready && m_last_q) begin
          drain_finish = 1'b1;
          state_d      = FILL;
        end else if (!m_valid_q || bus.m_ready) begin
          load_word = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  // NOTE: the storage array has no reset; stale words below the high-water mark are drained as-is.
  always_ff @(posedge clk) begin
    if (!rst && wr_commit) mem[idx] <= bus.wdata_HASH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      rd_ptr_q     <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_data_q     <= '0;
      rdata_q      <= '0;
      drain_done_q <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      rdata_q      <= mem[idx];
      drain_done_q <= flush_empty | drain_finish;
      if (wr_reject)        wr_err_q <= 1'b1;
      if (state_q == FILL)  count_q  <= count_eff;
      if (drain_start)      rd_ptr_q <= '0;
      // Pointer parks on the final index instead of stepping past it
      if (load_word) begin
        m_valid_q <= 1'b1;
        m_data_q  <= mem[rd_ptr_q];
        m_last_q  <= ptr_at_last;
        if (!ptr_at_last) rd_ptr_q <= rd_ptr_q + IDX_W'(1);
      end
      if (drain_finish) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
        count_q   <= '0;
      end
    end
  end

  assign bus.rdata_HASH = rdata_q;
  assign bus.HASH_ready = (state_q == FILL);
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = m_data_q;
  assign bus.m_last     = m_last_q;
  assign bus.drain_done = drain_done_q;
  assign bus.wr_err     = wr_err_q;
endmodule

// File: tb/tb_hash_wbuf_drain.sv
// Directed bench for hash_wbuf_drain: fill/flush/drain sequences, backpressure,
// error cases and reset mid-drain, checked against hand-computed values.
module tb_hash_wbuf_drain;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] q [$];

  always #5 clk = ~clk;

  hash_wbuf_drain_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus ();

  hash_wbuf_drain dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [63:0] data);
    bus.addr_HASH  = addr;
    bus.wdata_HASH = data;
    bus.wen_HASH   = 1'b1;
    step();
    bus.wen_HASH   = 1'b0;
  endtask

  task automatic flush_pulse();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
  endtask

  // Called just after the flush edge; consumes the whole stream and checks order,
  // m_last placement, stall stability, and the drain_done/HASH_ready handover.
  task automatic drain_check(input string tag, input logic [63:0] exp [$], input bit bp);
    logic [6:0]  rdy_pat = 7'b1001011;
    int          k = 0;
    int          cyc = 0;
    int          pi = 0;
    bit          stalled = 1'b0;
    logic [63:0] hold_d = '0;
    logic        hold_l = 1'b0;
    check({tag, " ready_low_at_flush"}, bus.HASH_ready, 1'b0);
    check({tag, " no_valid_at_flush"}, bus.m_valid, 1'b0);
    while (k < exp.size() && cyc < 200) begin
      if (stalled) begin
        check({tag, " stall_valid"}, bus.m_valid, 1'b1);
        check({tag, " stall_data"}, bus.m_data, hold_d);
        check({tag, " stall_last"}, bus.m_last, hold_l);
      end
      if (bus.m_valid) begin
        bus.m_ready = bp ? rdy_pat[6 - (pi % 7)] : 1'b1;
        pi++;
        if (bus.m_ready) begin
          check($sformatf("%s data[%0d]", tag, k), bus.m_data, exp[k]);
          check($sformatf("%s last[%0d]", tag, k), bus.m_last, (k == exp.size() - 1));
          k++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hold_d  = bus.m_data;
          hold_l  = bus.m_last;
        end
      end else begin
        bus.m_ready = 1'b1;
      end
      step();
      cyc++;
      if (k < exp.size()) check({tag, " busy"}, bus.HASH_ready, 1'b0);
    end
    check({tag, " handshakes"}, k, exp.size());
    bus.m_ready = 1'b0;
    check({tag, " done_pulse"}, bus.drain_done, 1'b1);
    check({tag, " valid_drop"}, bus.m_valid, 1'b0);
    check({tag, " ready_back"}, bus.HASH_ready, 1'b1);
    if (!bp) check({tag, " no_bubble_cycles"}, cyc, exp.size() + 1);
    step();
    check({tag, " done_single"}, bus.drain_done, 1'b0);
    check({tag, " valid_stays_low"}, bus.m_valid, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
  endtask

  initial begin
    bus.addr_HASH  = '0;
    bus.wen_HASH   = 1'b0;
    bus.wdata_HASH = '0;
    bus.flush      = 1'b0;
    bus.m_ready    = 1'b0;

    // Reset values
    do_reset();
    check("rst HASH_ready", bus.HASH_ready, 1'b1);
    check("rst m_valid", bus.m_valid, 1'b0);
    check("rst m_last", bus.m_last, 1'b0);
    check("rst m_data", bus.m_data, 64'h0);
    check("rst rdata", bus.rdata_HASH, 64'h0);
    check("rst drain_done", bus.drain_done, 1'b0);
    check("rst wr_err", bus.wr_err, 1'b0);
    rst = 1'b0;
    step();

    // Three-word block, full-rate drain
    wr(32'h00, 64'hA0);
    wr(32'h08, 64'hA1);
    wr(32'h10, 64'hA2);
    check("t1 ready_before_flush", bus.HASH_ready, 1'b1);
    flush_pulse();
    q = '{64'hA0, 64'hA1, 64'hA2};
    drain_check("t1", q, 1'b0);
    check("t1 wr_err", bus.wr_err, 1'b0);

    // Four words under backpressure 1,0,0,1,0,1,1
    wr(32'h00, 64'hD0);
    wr(32'h08, 64'hD1);
    wr(32'h10, 64'hD2);
    wr(32'h18, 64'hD3);
    flush_pulse();
    q = '{64'hD0, 64'hD1, 64'hD2, 64'hD3};
    drain_check("t2", q, 1'b1);

    // Sparse write: index 1 only, index 0 drains stale contents
    wr(32'h08, 64'hB);
    flush_pulse();
    q = '{64'hD0, 64'hB};
    drain_check("t3", q, 1'b0);
    wr(32'h100, 64'h5555);
    check("t3 oob wr_err", bus.wr_err, 1'b1);
    bus.addr_HASH = 32'h00;
    step();
    check("t3 oob mem0_kept", bus.rdata_HASH, 64'hD0);

    // Empty flush (out-of-range write left count at 0)
    flush_pulse();
    check("t6 empty done", bus.drain_done, 1'b1);
    check("t6 empty ready", bus.HASH_ready, 1'b1);
    check("t6 empty valid", bus.m_valid, 1'b0);
    step();
    check("t6 empty done_single", bus.drain_done, 1'b0);
    check("t6 empty valid_low", bus.m_valid, 1'b0);
    do_reset();
    check("t6 rst clears wr_err", bus.wr_err, 1'b0);
    rst = 1'b0;
    step();

    // Flush coincident with the write of the last word
    wr(32'h00, 64'hE0);
    wr(32'h08, 64'hE1);
    wr(32'h10, 64'hE2);
    bus.addr_HASH  = 32'h18;
    bus.wdata_HASH = 64'hC;
    bus.wen_HASH   = 1'b1;
    bus.flush      = 1'b1;
    step();
    bus.wen_HASH   = 1'b0;
    bus.flush      = 1'b0;
    q = '{64'hE0, 64'hE1, 64'hE2, 64'hC};
    drain_check("t4", q, 1'b0);
    check("t4 wr_err", bus.wr_err, 1'b0);

    // Write during drain is dropped; reset mid-drain aborts the stream
    wr(32'h00, 64'hF0);
    wr(32'h08, 64'hF1);
    flush_pulse();
    wr(32'h00, 64'hDEAD);
    check("t5 drain_write wr_err", bus.wr_err, 1'b1);
    check("t5 drain_write ready", bus.HASH_ready, 1'b0);
    bus.addr_HASH = 32'h00;
    step();
    check("t5 mem0_unchanged", bus.rdata_HASH, 64'hF0);
    check("t5 stalled_valid", bus.m_valid, 1'b1);
    rst = 1'b1;
    step();
    check("t5 rst m_valid", bus.m_valid, 1'b0);
    check("t5 rst HASH_ready", bus.HASH_ready, 1'b1);
    check("t5 rst wr_err", bus.wr_err, 1'b0);
    check("t5 rst m_last", bus.m_last, 1'b0);
    rst = 1'b0;
    bus.m_ready = 1'b1;
    step();
    step();
    check("t5 no_resume valid", bus.m_valid, 1'b0);
    check("t5 no_resume done", bus.drain_done, 1'b0);
    bus.m_ready = 1'b0;

    // Full buffer: all DEPTH words, last on index 31
    q = {};
    for (int i = 0; i < 32; i++) begin
      wr(32'(i * 8), 64'hF000 + 64'(i));
      q.push_back(64'hF000 + 64'(i));
    end
    flush_pulse();
    drain_check("full", q, 1'b0);

    // Read-during-write returns the old word
    wr(32'h00, 64'hBEEF);
    check("rdw old_data", bus.rdata_HASH, 64'hF000);
    step();
    check("rdw new_data", bus.rdata_HASH, 64'hBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
